// File: rtl/if_fetch_control.sv
// Instruction-fetch control: PC register, imem address, IF/ID side-band (PC, PC+4, valid).
// Optional FETCH_PERF_CNT_EN adds saturating fetch/stall cycle counters.
module if_fetch_control #(
    parameter int unsigned         XLEN         = 32,
    parameter logic [XLEN-1:0]     RESET_VECTOR = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stallF_i,
    input  logic            stallD_i,
    input  logic            flushD_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            halt_i,
    output logic [XLEN-1:0] aF_o,
    output logic [XLEN-1:0] pcD_o,
    output logic [XLEN-1:0] pcplus4D_o,
    output logic            validD_o,
    output logic            halted_o,
    output logic            misalignF_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     fetch_cnt_o,
    output logic [31:0]     stall_cnt_o
`endif
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_nxt;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] pcd_nxt;
    logic [XLEN-1:0] pc4_nxt;
    logic            vd_nxt;
    logic            mis_nxt;
    logic            kill;

    assign pc_plus4 = pc + PC_STEP;
    assign aF_o     = pc;

    // Next state / next PC; kill marks edges whose fetched instruction must not reach Decode.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        mis_nxt   = misalignF_o;
        kill      = 1'b0;
        pcd_nxt   = pcD_o;
        pc4_nxt   = pcplus4D_o;
        case (state)
            ST_BOOT: state_nxt = ST_RUN;
            ST_RUN: begin
                if (redirect_i) begin
                    pc_nxt = {redirect_pc_i[XLEN-1:2], 2'b00};
                    kill   = 1'b1;
                    if (redirect_pc_i[1:0] != 2'b00) begin
                        mis_nxt = 1'b1;
                    end
                end else if (halt_i) begin
                    state_nxt = ST_HALT;
                    kill      = 1'b1;
                end else if (!stallF_i) begin
                    pc_nxt = pc_plus4;
                end
            end
            ST_HALT: kill = 1'b1;
            default: state_nxt = ST_BOOT;
        endcase

        vd_nxt = validD_o & ~kill;
        if (flushD_i) begin
            pcd_nxt = '0;
            pc4_nxt = '0;
            vd_nxt  = 1'b0;
        end else if (!stallD_i) begin
            pcd_nxt = pc;
            pc4_nxt = pc_plus4;
            vd_nxt  = (state == ST_RUN) & ~kill;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= ST_BOOT;
            pc          <= RESET_VECTOR;
            pcD_o       <= '0;
            pcplus4D_o  <= '0;
            validD_o    <= 1'b0;
            halted_o    <= 1'b0;
            misalignF_o <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            pcD_o       <= pcd_nxt;
            pcplus4D_o  <= pc4_nxt;
            validD_o    <= vd_nxt;
            halted_o    <= (state_nxt == ST_HALT);
            misalignF_o <= mis_nxt;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    // Counters only advance in RUN, so they freeze naturally in BOOT and HALT.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fetch_cnt_o <= '0;
            stall_cnt_o <= '0;
        end else if (state == ST_RUN) begin
            if (stallF_i) begin
                if (stall_cnt_o != CNT_MAX) begin
                    stall_cnt_o <= stall_cnt_o + 32'(1);
                end
            end else if (fetch_cnt_o != CNT_MAX) begin
                fetch_cnt_o <= fetch_cnt_o + 32'(1);
            end
        end
    end
`endif

endmodule
